// File: rtl/core_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the RV32 run/boot sequencer:
//   state_e      - sequencer state encoding (3 bits, IDLE..HALT)
//   HALT_*       - halt_cause codes reported to the host
//   OPC_SYSTEM   - RV32 SYSTEM major opcode (ECALL/EBREAK live here)
//   halt_pick()  - resolves simultaneous halt sources into one cause code
// -----------------------------------------------------------------------------
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_PAUSE = 3'd5,
        ST_HALT  = 3'd6
    } state_e;

    localparam logic [1:0] HALT_NONE = 2'b00;
    localparam logic [1:0] HALT_SYS  = 2'b01;
    localparam logic [1:0] HALT_HOST = 2'b10;
    localparam logic [1:0] HALT_WDOG = 2'b11;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Core-originated halts outrank host requests, which outrank the watchdog.
    function automatic logic [1:0] halt_pick(input logic sys_hit,
                                             input logic host_hit,
                                             input logic wdog_hit);
        logic [1:0] code;
        if (sys_hit) begin
            code = HALT_SYS;
        end else if (host_hit) begin
            code = HALT_HOST;
        end else if (wdog_hit) begin
            code = HALT_WDOG;
        end else begin
            code = HALT_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/core_run_ctrl_sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
// 32-bit up-counter that sticks at all-ones instead of wrapping.
//   clk, reset : clock and synchronous active-high reset (clears q)
//   clr        : synchronous clear, wins over inc
//   inc        : count enable
//   q          : current count
// -----------------------------------------------------------------------------
module sat_counter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 32'd0;
        end else if (inc && (q_q != 32'hFFFF_FFFF)) begin
            q_d = q_q + 32'd1;
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 32'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
// Run/boot sequencer for the single-cycle RV32 core. Streams a host program into
// instruction memory while holding the core in reset, then lets the core run
// freely or single-step, halting on ECALL/EBREAK, host request or watchdog.
//   load_start / ld_valid / ld_ready / ld_data / ld_last : host program stream
//   imem_we / imem_waddr / imem_wdata                    : imem write port
//   run_start / step_req / halt_req / halt_clr           : host run control
//   instr                                                : instruction in execution
//   core_reset / core_clk_en                             : core reset and advance
//   halted / halt_cause / cycle_cnt                      : status to host
// -----------------------------------------------------------------------------
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    input  logic              run_start,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              halt_clr,
    input  logic [31:0]       instr,
    output logic              core_reset,
    output logic              core_clk_en,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [31:0]       cycle_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic              WDOG_EN   = (MAX_CYCLES != 0);
    // Watchdog fires while executing the MAX_CYCLES-th enabled cycle.
    localparam logic [31:0]       WDOG_LAST = 32'(MAX_CYCLES) - 32'd1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cause_q, cause_d;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic [31:0]       cnt_s;
    logic              hs_s;
    logic              sys_hit_s;
    logic              wdog_hit_s;
    logic [1:0]        halt_code_s;
    logic              unused_instr_s;

    sat_counter32 u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .q     (cnt_s)
    );

    // Only the opcode field decides a SYSTEM halt; ECALL and EBREAK both qualify.
    assign sys_hit_s      = (instr[6:0] == OPC_SYSTEM);
    assign unused_instr_s = ^instr[31:7];
    assign wdog_hit_s     = WDOG_EN && (cnt_s == WDOG_LAST);
    assign halt_code_s    = halt_pick(sys_hit_s, halt_req, wdog_hit_s);
    assign hs_s           = ld_valid & ld_ready;

    // State register with load address and latched halt cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_ZERO;
            cause_q <= HALT_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cause_q <= cause_d;
        end
    end

    // Next-state, load address and halt cause logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cause_d   = cause_q;
        cnt_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    addr_d  = ADDR_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    if (ld_last || (addr_q == ADDR_LAST)) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_LOAD;
                    end
                    // The address parks on the last word rather than wrapping.
                    if (addr_q != ADDR_LAST) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        addr_d = addr_q;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READY: begin
                if (run_start) begin
                    state_d   = ST_RUN;
                    cause_d   = HALT_NONE;
                    cnt_clr_s = 1'b1;
                end else if (step_req) begin
                    state_d   = ST_STEP;
                    cause_d   = HALT_NONE;
                    cnt_clr_s = 1'b1;
                end else if (load_start) begin
                    state_d = ST_LOAD;
                    addr_d  = ADDR_ZERO;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_RUN, ST_STEP: begin
                if (halt_code_s != HALT_NONE) begin
                    state_d = ST_HALT;
                    cause_d = halt_code_s;
                end else if (state_q == ST_RUN) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end else if (load_start) begin
                    state_d = ST_LOAD;
                    addr_d  = ADDR_ZERO;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                    cause_d = HALT_HOST;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_HALT: begin
                if (halt_clr) begin
                    state_d = ST_READY;
                end else if (load_start) begin
                    state_d = ST_LOAD;
                    addr_d  = ADDR_ZERO;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = ADDR_ZERO;
                cause_d = HALT_NONE;
            end
        endcase
    end

    // Output decode: everything except the imem write strobe/data is a state decode.
    always_comb begin
        ld_ready    = 1'b0;
        core_reset  = 1'b1;
        core_clk_en = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                core_reset = 1'b1;
            end
            ST_LOAD: begin
                core_reset = 1'b1;
                ld_ready   = 1'b1;
            end
            ST_RUN, ST_STEP: begin
                core_reset  = 1'b0;
                core_clk_en = 1'b1;
            end
            ST_PAUSE: begin
                core_reset = 1'b0;
            end
            ST_HALT: begin
                core_reset = 1'b0;
                halted     = 1'b1;
            end
            default: begin
                core_reset = 1'b1;
            end
        endcase
        cnt_inc_s  = core_clk_en;
        imem_we    = ld_valid & ld_ready;
        imem_wdata = ld_data;
        imem_waddr = addr_q;
        halt_cause = cause_q;
        cycle_cnt  = cnt_s;
    end

endmodule
